sram_req_arbiter: RTL
=====================

# sram_req_arbiter

Three-way request arbiter in front of the single SRAM request port of the memory controller. It accepts independent read/write requests from IO (port 0), core data (port 1) and core fetch/DMA (port 2), and grants one at a time in round-robin order. It holds the winner's command stable to the memory port until completion and returns a one-cycle done pulse with read data. A timeout watchdog aborts transactions the memory side never completes.

## Interface
Parameters:
- AW, 19, SRAM address width
- DW, 8, data width
- TIMEOUT, 255, max cycles in BUSY before abort (1..255)

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-low
- req  in  3  per-port request level, bit i = port i
- we  in  3  per-port write enable (1 = write)
- addr  in  3*AW  port i address at [i*AW +: AW]
- wdata  in  3*DW  port i write data at [i*DW +: DW]
- gnt  out  3  one-hot owner, high in BUSY and RESP
- done  out  3  one-cycle completion pulse to owner
- err  out  1  high with done when the transaction timed out
- rdata  out  DW  read data, valid while done is high
- mem_req  out  1  request level to memory controller
- mem_we  out  1  write enable to memory controller
- mem_addr  out  AW  address to memory controller
- mem_wdata  out  DW  write data to memory controller
- mem_done  in  1  memory operation complete, sampled in BUSY only
- mem_rdata  in  DW  memory read data, valid with mem_done

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any req bit is set, the picker selects the winner, searching ptr+1, ptr+2, ptr (mod 3). The arbiter latches we/addr/wdata into mem_*, sets gnt, mem_req=1, clears the timeout counter, and goes to BUSY. If no req bit is set it stays in IDLE with mem_req=0.
- BUSY: mem_* are frozen. Requester inputs are ignored, including a deassertion of req by the owner.
  - On mem_done: mem_req is cleared, done[g] is set, rdata is loaded from mem_rdata on a read or 0 on a write, err=0, ptr is set to g, and the state goes to RESP.
  - Otherwise the counter increments. When it equals TIMEOUT: mem_req is cleared, done[g] is set, err=1, rdata=0, ptr is set to g, and the state goes to RESP.
- RESP: done/err/rdata are held for this one cycle, then cleared along with gnt, and the state returns to IDLE. No arbitration happens in RESP, so a requester's req that is still high in its done cycle is never regranted.
- Requester rule: hold req/we/addr/wdata stable from assertion until done. In the cycle after done, either deassert req or present a new command.
- ptr resets to 2, so port 0 wins first after reset.
- mem_done outside BUSY is ignored.
- The counter is 8 bits and saturates. It is only meaningful in BUSY.

## Timing
- Reset, asynchronous, any state: state=IDLE, ptr=2, counter=0. All outputs are 0: gnt, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata. A transaction in flight is dropped without a done pulse.
- All outputs are registered.
- req seen in IDLE at cycle 0 → mem_req=1 and gnt valid at cycle 1.
- mem_done at cycle k → mem_req=0 and done=1 at k+1 (RESP) → IDLE at k+2. A pending request is granted with mem_req=1 at k+3.
- Minimum turnaround is 4 cycles per transaction when mem_done comes one cycle after mem_req.
- mem_req first high at cycle 1 with no mem_done → done with err at cycle 1+TIMEOUT+1.

## Structure
- Package sram_arb_pkg holds:
  - state enum IDLE=2'd0, BUSY=2'd1, RESP=2'd2
  - NREQ=3
  - the counter width
- Sub-module arb_rr_pick: combinational round-robin picker. Inputs req[2:0] and ptr[1:0]; outputs a one-hot grant and a 2-bit index. Instantiated once.
- The FSM, counter, and command/response registers live in the top level.

## Test plan
- Single read: port 1 reads addr 0x00123, memory returns 0xA5 with mem_done 2 cycles after mem_req → mem_addr=0x00123, mem_we=0, done=3'b010, rdata=0xA5, err=0.
- Single write: port 0 writes 0x3C to 0x7FFFF → mem_we=1, mem_wdata=0x3C, done=3'b001, rdata=0x00.
- Fairness: all three req held continuously after reset, each completion one cycle after mem_req → grant order 0,1,2,0,1,2. No port is granted twice before the others are served.
- No regrant in RESP: port 2 alone keeps req high through its done cycle → exactly one done per intended transaction. A second grant appears only if req is still high at IDLE.
- Timeout: TIMEOUT=4, mem_done never asserted → done[g]=1 with err=1 and rdata=0 exactly 5 cycles after mem_req rises, then IDLE.
- Reset mid-op: clr low during BUSY → all outputs 0 immediately. After release, port 0 is granted first.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the three-port SRAM request arbiter.
package sram_arb_pkg;

  localparam int NREQ  = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ptr (mod NREQ).
module arb_rr_pick
  import sram_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      idx
);

  always_comb begin
    logic found;
    int   c;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        gnt[c] = 1'b1;
        idx    = 2'(c);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter in front of the single SRAM request port, with a
// timeout watchdog that aborts transactions the memory never completes.
//
// state | meaning
// IDLE  | no owner; pick a winner from req and launch its command
// BUSY  | mem_* frozen for the owner; wait for mem_done or timeout
// RESP  | one-cycle done/err/rdata to the owner; no arbitration
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW      = 19,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [DW-1:0]        rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic                 mem_done,
  input  logic [DW-1:0]        mem_rdata
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t            state;
  logic [1:0]        ptr;
  logic [1:0]        own;
  logic [CNT_W-1:0]  cnt;
  logic [NREQ-1:0]   pick_gnt;
  logic [1:0]        pick_idx;

  arb_rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      ptr       <= 2'd2;
      own       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= pick_gnt;
            own       <= pick_idx;
            mem_req   <= 1'b1;
            mem_we    <= we[pick_idx];
            mem_addr  <= addr[pick_idx*AW +: AW];
            mem_wdata <= wdata[pick_idx*DW +: DW];
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // A completion in the same cycle as the terminal count wins.
          if (mem_done) begin
            mem_req <= 1'b0;
            done    <= gnt;
            rdata   <= mem_we ? '0 : mem_rdata;
            err     <= 1'b0;
            ptr     <= own;
            state   <= RESP;
          end else if (cnt == TO_CNT) begin
            mem_req <= 1'b0;
            done    <= gnt;
            rdata   <= '0;
            err     <= 1'b1;
            ptr     <= own;
            state   <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          done  <= '0;
          err   <= 1'b0;
          rdata <= '0;
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
